// File: rtl/io_ccff_chain_ctrl.sv
// io_ccff_chain_ctrl
//   Sequencer for the configuration flip-flop chain of an IO grid column.
//   LOAD serialises config-bus words into the chain (exactly CHAIN_LEN shifts).
//   READBACK recirculates the chain (tail -> head) and returns its contents as
//   words, leaving the chain unchanged. IO isolation is held until a full LOAD.
// Ports
//   prog_clk, pReset        programming clock, synchronous active-low reset
//   cmd_valid/ready/op      command handshake, op 0 = LOAD, 1 = READBACK
//   wr_valid/ready/data     load word stream, bit 0 shifted first
//   rd_valid/ready/data     readback word stream, bit 0 = first bit from tail
//   ccff_head/tail/en       chain serial in, serial out, shift enable
//   isol_n, busy, done      isolation release, not-idle flag, end-of-op pulse
module io_ccff_chain_ctrl #(
   parameter int unsigned CHAIN_LEN = 4,
   parameter int unsigned WORD_W    = 4
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [WORD_W-1:0] rd_data,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_en,
   output logic              isol_n,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW    = $clog2(CHAIN_LEN + 1);
   localparam int unsigned KW    = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] LEN_C = CW'(CHAIN_LEN);
   localparam logic [KW-1:0] WW_C  = KW'(WORD_W);

   typedef enum logic [2:0] {
      IDLE, LD_WAIT, LD_SHIFT, RB_SHIFT, RB_HOLD, FIN
   } state_t;

   state_t            state;
   logic [CW-1:0]     bitcnt;
   logic [KW-1:0]     k;
   logic [KW-1:0]     nbits;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] colreg;
   logic              op_rb;
   logic              cfg_done;

   logic [31:0]       rem;
   logic [KW-1:0]     nbits_nx;
   logic [KW-1:0]     k_inc;
   logic [WORD_W-1:0] col_nx;
   logic              last_bit;

   always_comb begin
      // bits still owed to the chain bound the size of the next word
      rem      = CHAIN_LEN - 32'(bitcnt);
      nbits_nx = (rem < WORD_W) ? KW'(rem) : WW_C;
      k_inc    = k + 1'b1;
      last_bit = (bitcnt + 1'b1) == LEN_C;
      col_nx   = colreg;
      for (int unsigned i = 0; i < WORD_W; i++) begin
         if (32'(k) == i) col_nx[i] = ccff_tail;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (!pReset) begin
         state    <= IDLE;
         bitcnt   <= '0;
         k        <= '0;
         nbits    <= '0;
         shreg    <= '0;
         colreg   <= '0;
         rd_data  <= '0;
         op_rb    <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  bitcnt <= '0;
                  k      <= '0;
                  colreg <= '0;
                  op_rb  <= cmd_op;
                  if (cmd_op) begin
                     state <= RB_SHIFT;
                  end else begin
                     cfg_done <= 1'b0;
                     state    <= LD_WAIT;
                  end
               end
            end
            LD_WAIT: begin
               if (wr_valid) begin
                  shreg <= wr_data;
                  nbits <= nbits_nx;
                  k     <= '0;
                  state <= LD_SHIFT;
               end
            end
            LD_SHIFT: begin
               shreg  <= shreg >> 1;
               bitcnt <= bitcnt + 1'b1;
               k      <= k_inc;
               if (k_inc == nbits) state <= last_bit ? FIN : LD_WAIT;
            end
            RB_SHIFT: begin
               colreg <= col_nx;
               bitcnt <= bitcnt + 1'b1;
               k      <= k_inc;
               if (k_inc == WW_C || last_bit) begin
                  rd_data <= col_nx;
                  state   <= RB_HOLD;
               end
            end
            RB_HOLD: begin
               if (rd_ready) begin
                  k      <= '0;
                  colreg <= '0;
                  state  <= (bitcnt == LEN_C) ? FIN : RB_SHIFT;
               end
            end
            FIN: begin
               if (!op_rb) cfg_done <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign wr_ready  = (state == LD_WAIT);
   assign rd_valid  = (state == RB_HOLD);
   assign ccff_en   = (state == LD_SHIFT) || (state == RB_SHIFT);
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign isol_n    = cfg_done && (state == IDLE);
   // readback recirculates combinationally so the chain returns to its start
   assign ccff_head = (state == LD_SHIFT) ? shreg[0] :
                      (state == RB_SHIFT) ? ccff_tail : 1'b0;

endmodule

// File: tb/tb_io_ccff_chain_ctrl.sv
// tb_io_ccff_chain_ctrl
//   Randomised bench for io_ccff_chain_ctrl (CHAIN_LEN=10, WORD_W=4).
//   A behavioural chain (shift register fed by ccff_head, tail = bit 0) stands
//   in for the IO column; expected chain/readback words come from the loaded
//   word list by plain bit arithmetic.
module tb_io_ccff_chain_ctrl;

   localparam int CL = 10;
   localparam int WW = 4;
   localparam int NW = (CL + WW - 1) / WW;

   logic          clk = 1'b0;
   logic          preset_n;
   logic          cmd_valid, cmd_op, cmd_ready;
   logic          wr_valid, wr_ready;
   logic [WW-1:0] wr_data;
   logic          rd_valid, rd_ready;
   logic [WW-1:0] rd_data;
   logic          ccff_head, ccff_tail, ccff_en;
   logic          isol_n, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [CL-1:0] chain = '0;
   int            cyc = 0, done_cnt = 0, done_cyc = 0, en_cnt = 0;
   int            acc_cyc;
   logic [CL-1:0] exp_chain;
   bit            model_cfg;

   always #5 clk = ~clk;

   io_ccff_chain_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk (clk),
      .pReset   (preset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .ccff_head(ccff_head),
      .ccff_tail(ccff_tail),
      .ccff_en  (ccff_en),
      .isol_n   (isol_n),
      .busy     (busy),
      .done     (done)
   );

   assign ccff_tail = chain[0];

   // physical chain plus event counters
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (ccff_en) begin
         en_cnt <= en_cnt + 1;
         chain  <= {ccff_head, chain[CL-1:1]};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CL-1:0] stream(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                            input logic [WW-1:0] c);
      logic [WW-1:0] ws [3];
      logic [CL-1:0] s;
      ws[0] = a; ws[1] = b; ws[2] = c;
      s = '0;
      for (int i = 0; i < CL; i++) s[i] = ws[i / WW][i % WW];
      return s;
   endfunction

   function automatic logic [WW-1:0] rb_word(input logic [CL-1:0] e, input int j);
      logic [WW-1:0] r;
      r = '0;
      for (int b = 0; b < WW; b++) if (j * WW + b < CL) r[b] = e[j * WW + b];
      return r;
   endfunction

   task automatic start_cmd(input logic op, input bit with_word, input logic [WW-1:0] w);
      int t = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      if (with_word) begin
         wr_valid = 1'b1;
         wr_data  = w;
      end
      while (!cmd_ready && t < 50) begin step(); t++; end
      if (t >= 50) check("cmd_timeout", 0, 1);
      step();
      cmd_valid = 1'b0;
      acc_cyc   = cyc;
      check("busy_after_cmd", busy, 1);
      check("isol_during_cmd", isol_n, 0);
      if (op) check("rb_first_en", ccff_en, 1);
      else    check("wr_ready_lat", wr_ready, 1);
      if (with_word) check("word_held_off", ccff_en, 0);
   endtask

   task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                          input int gmin, input int gmax, input bit overlap, input bit poke,
                          input bit chk_lat);
      logic [WW-1:0] ws [3];
      int en0, d0, t, g;
      ws[0] = w0; ws[1] = w1; ws[2] = w2;
      en0 = en_cnt;
      d0  = done_cnt;
      start_cmd(1'b0, overlap, w0);
      model_cfg = 1'b0;
      for (int i = 0; i < NW; i++) begin
         if (!(i == 0 && overlap)) begin
            t = 0;
            while (!wr_ready && t < 50) begin
               cmd_valid = poke;
               cmd_op    = 1'b1;
               if (poke) check("cmd_ignored_busy", cmd_ready, 0);
               step();
               t++;
            end
            cmd_valid = 1'b0;
            if (t >= 50) check("wr_ready_timeout", 0, 1);
            g = $urandom_range(gmax, gmin);
            for (int s = 0; s < g; s++) begin
               check("gap_en", ccff_en, 0);
               check("gap_wr_ready", wr_ready, 1);
               step();
            end
            wr_valid = 1'b1;
            wr_data  = ws[i];
         end
         step();
         wr_valid = 1'b0;
         wr_data  = WW'($urandom);
         check("word_to_en_lat", ccff_en, 1);
      end
      t = 0;
      while (done_cnt == d0 && t < 100) begin step(); t++; end
      if (t >= 100) check("load_done_timeout", 0, 1);
      model_cfg = 1'b1;
      exp_chain = stream(w0, w1, w2);
      check("load_en_cycles", en_cnt - en0, CL);
      check("load_chain", chain, exp_chain);
      check("isol_after_load", isol_n, 1);
      check("busy_after_load", busy, 0);
      check("done_one_pulse", done_cnt - d0, 1);
      if (chk_lat) check("load_latency", done_cyc - acc_cyc + 1, CL + NW + 1);
   endtask

   task automatic do_readback(input int stall_word, input int stall_len);
      int en0, d0, t;
      logic [WW-1:0] e;
      en0 = en_cnt;
      d0  = done_cnt;
      start_cmd(1'b1, 1'b0, '0);
      for (int j = 0; j < NW; j++) begin
         t = 0;
         while (!rd_valid && t < 50) begin step(); t++; end
         if (t >= 50) check("rd_valid_timeout", 0, 1);
         e = rb_word(exp_chain, j);
         check("rd_data", rd_data, e);
         check("isol_during_rb", isol_n, 0);
         if (j == stall_word) begin
            for (int s = 0; s < stall_len; s++) begin
               check("hold_en", ccff_en, 0);
               check("hold_valid", rd_valid, 1);
               check("hold_data", rd_data, e);
               step();
            end
         end
         rd_ready = 1'b1;
         step();
         rd_ready = 1'b0;
         check("rd_valid_drop", rd_valid, 0);
      end
      t = 0;
      while (done_cnt == d0 && t < 100) begin step(); t++; end
      if (t >= 100) check("rb_done_timeout", 0, 1);
      check("rb_en_cycles", en_cnt - en0, CL);
      check("rb_chain_kept", chain, exp_chain);
      check("isol_after_rb", isol_n, model_cfg);
      check("done_low_idle", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      preset_n  = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_ready  = 1'b0;
      model_cfg = 1'b0;
      exp_chain = '0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_isol", isol_n, 0);
      check("rst_en", ccff_en, 0);
      check("rst_head", ccff_head, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_wr_ready", wr_ready, 0);
      preset_n = 1'b1;
      step();
      check("post_rst_isol", isol_n, 0);

      // reset in the middle of a shift
      start_cmd(1'b0, 1'b0, '0);
      wr_valid = 1'b1;
      wr_data  = WW'($urandom);
      step();
      wr_valid = 1'b0;
      step();
      check("mid_shift_en", ccff_en, 1);
      preset_n = 1'b0;
      step();
      preset_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_en", ccff_en, 0);
      check("abort_isol", isol_n, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_done", done, 0);
      model_cfg = 1'b0;

      // zero-stall load with latency check, then readbacks
      do_load(WW'($urandom), WW'($urandom), WW'($urandom), 0, 0, 1'b0, 1'b0, 1'b1);
      do_readback(NW, 0);
      do_readback(1, 5);

      // fixed words with 3-cycle gaps; top bits of the last word drop out
      do_load(4'hA, 4'h5, 4'hF, 3, 3, 1'b0, 1'b0, 1'b0);
      check("t3_chain", chain, 32'h35A);
      do_readback(NW, 0);

      // command and word together, plus commands poked while busy
      do_load(WW'($urandom), WW'($urandom), WW'($urandom), 0, 2, 1'b1, 1'b1, 1'b0);
      step();
      check("no_stray_cmd", busy, 0);
      step();
      check("no_stray_cmd2", busy, 0);

      for (int r = 0; r < 8; r++) begin
         do_load(WW'($urandom), WW'($urandom), WW'($urandom), 0, 3,
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
         do_readback($urandom_range(NW - 1, 0), $urandom_range(4, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
